// File: rtl/game_controller_if.sv
// Move handshake between a move source (master) and the turn sequencer (slave).
interface game_controller_if;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_accept;
  logic       move_reject;

  modport master (output move_valid, output move_pos, input move_accept, input move_reject);
  modport slave  (input move_valid, input move_pos, output move_accept, output move_reject);
endinterface

// File: rtl/game_controller.sv
// Tic-tac-toe turn sequencer: owns the 3x3 board, alternates P1/P2, latches the checker outcome.
// Optional per-turn time limit enabled by defining TURN_TIMEOUT_EN.
module game_controller #(
  parameter int TURN_CYCLES = 50_000_000,
  parameter int TMR_W       = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  game_controller_if.slave    mv,
  input  logic [2:0]          outcome_in,
  output logic [1:0]          grid_A1,
  output logic [1:0]          grid_A2,
  output logic [1:0]          grid_A3,
  output logic [1:0]          grid_B1,
  output logic [1:0]          grid_B2,
  output logic [1:0]          grid_B3,
  output logic [1:0]          grid_C1,
  output logic [1:0]          grid_C2,
  output logic [1:0]          grid_C3,
  output logic [1:0]          turn,
  output logic [3:0]          move_count,
  output logic                game_over,
  output logic [1:0]          result,
  output logic                timeout
);

  if ((64'd1 << TMR_W) <= 64'(TURN_CYCLES)) begin : g_tmr_check
    $error("TMR_W too narrow for TURN_CYCLES");
  end

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_CHECK, S_OVER} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  grid_reg [9];
  logic [8:0]  occupied;
  logic [15:0] busy_ext;
  logic        cell_busy;
  logic [1:0]  mover;
  logic        write_en;
  logic [3:0]  count_reg, count_next;
  logic [1:0]  result_reg, result_next;
  logic        last_reg, last_next;
  logic        accept_reg, accept_next;
  logic        reject_reg, reject_next;
  logic [1:0]  outc;

`ifdef TURN_TIMEOUT_EN
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             timeout_reg, timeout_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign occupied[gi] = (grid_reg[gi] != 2'b00);
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          grid_reg[gi] <= 2'b00;
        else if (start)
          grid_reg[gi] <= 2'b00;
        else if (write_en && (mv.move_pos == 4'(gi)))
          grid_reg[gi] <= mover;
      end
    end
  endgenerate

  // Indices 9..15 read as busy so one lookup covers both illegal cases.
  assign busy_ext  = {7'h7f, occupied};
  assign cell_busy = busy_ext[mv.move_pos];
  assign mover     = (state_reg == S_P2) ? 2'b10 : 2'b01;
  assign outc      = outcome_in[2] ? 2'b00 : outcome_in[1:0];

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    result_next = result_reg;
    last_next   = last_reg;
    accept_next = 1'b0;
    reject_next = 1'b0;
    write_en    = 1'b0;
`ifdef TURN_TIMEOUT_EN
    timer_next   = '0;
    timeout_next = 1'b0;
`endif
    if (start) begin
      state_next  = S_P1;
      count_next  = 4'd0;
      result_next = 2'b00;
    end else begin
      case (state_reg)
        S_IDLE: ;
        S_P1, S_P2: begin
          if (mv.move_valid && !cell_busy) begin
            write_en    = 1'b1;
            count_next  = count_reg + 4'd1;
            accept_next = 1'b1;
            last_next   = (state_reg == S_P2);
            state_next  = S_CHECK;
          end else begin
            reject_next = mv.move_valid;
`ifdef TURN_TIMEOUT_EN
            if (timer_reg == TMR_W'(TURN_CYCLES - 1)) begin
              timeout_next = 1'b1;
              state_next   = (state_reg == S_P1) ? S_P2 : S_P1;
            end else begin
              timer_next = timer_reg + TMR_W'(1);
            end
`endif
          end
        end
        S_CHECK: begin
          if (outc != 2'b00) begin
            state_next  = S_OVER;
            result_next = outc;
          end else begin
            state_next = last_reg ? S_P1 : S_P2;
          end
        end
        S_OVER: ;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      count_reg  <= 4'd0;
      result_reg <= 2'b00;
      last_reg   <= 1'b0;
      accept_reg <= 1'b0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      result_reg <= result_next;
      last_reg   <= last_next;
      accept_reg <= accept_next;
      reject_reg <= reject_next;
    end
  end

`ifdef TURN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timer_reg   <= timer_next;
      timeout_reg <= timeout_next;
    end
  end
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  assign grid_A1 = grid_reg[0];
  assign grid_A2 = grid_reg[1];
  assign grid_A3 = grid_reg[2];
  assign grid_B1 = grid_reg[3];
  assign grid_B2 = grid_reg[4];
  assign grid_B3 = grid_reg[5];
  assign grid_C1 = grid_reg[6];
  assign grid_C2 = grid_reg[7];
  assign grid_C3 = grid_reg[8];

  assign turn           = (state_reg == S_P1) ? 2'b01 : (state_reg == S_P2) ? 2'b10 : 2'b00;
  assign game_over      = (state_reg == S_OVER);
  assign result         = result_reg;
  assign move_count     = count_reg;
  assign mv.move_accept = accept_reg;
  assign mv.move_reject = reject_reg;

endmodule
